adder_tree_feeder: RTL and testbench

Stream-side driver and result collector for the pipelined adder tree. It accepts a valid/ready stream of DATAWIDTH-bit words and packs up to NUM_INPUTS words into one lane vector, zero-padding when a packet ends early. It issues each vector as a single-cycle valid pulse into the tree and gathers the returning sums with their element counts into a result FIFO with valid/ready backpressure. The tree cannot stall, so the block issues a vector only when a result slot is guaranteed.

---
 rtl/adder_tree_feeder_if.sv | 46 ++++
 rtl/adder_tree_feeder.sv | 141 ++++++++++++++
 tb/tb_adder_tree_feeder.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_tree_feeder_if.sv
// Signal bundle between adder_tree_feeder and its neighbours: the word stream in,
// the lane vector / sum exchange with the adder tree, and the result stream out.
interface adder_tree_feeder_if #(
    parameter int DATAWIDTH  = 4,
    parameter int NUM_INPUTS = 16,
    parameter int SUM_W      = DATAWIDTH + $clog2(NUM_INPUTS - 1) + 2,
    parameter int CNT_W      = $clog2(NUM_INPUTS + 1)
);
    logic                                 s_valid;
    logic                                 s_ready;
    logic [DATAWIDTH-1:0]                 s_data;
    logic                                 s_last;

    logic                                 t_valid;
    logic [NUM_INPUTS-1:0][DATAWIDTH-1:0] t_data;
    logic                                 t_sum_valid;
    logic [SUM_W-1:0]                     t_sum;

    logic                                 m_valid;
    logic                                 m_ready;
    logic [SUM_W-1:0]                     m_sum;
    logic [CNT_W-1:0]                     m_count;

    logic                                 err_unexpected;

    // master is the surrounding environment (word source, tree, result sink)
    modport master (
        output s_valid, s_data, s_last,
        input  s_ready,
        input  t_valid, t_data,
        output t_sum_valid, t_sum,
        input  m_valid, m_sum, m_count,
        output m_ready,
        input  err_unexpected
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready,
        output t_valid, t_data,
        input  t_sum_valid, t_sum,
        output m_valid, m_sum, m_count,
        input  m_ready,
        output err_unexpected
    );
endinterface

// File: rtl/adder_tree_feeder.sv
// Packs stream words into lane vectors for a non-stalling adder tree and collects
// the returning sums, tagged with their word counts, into a result FIFO.
module adder_tree_feeder #(
    parameter int DATAWIDTH  = 4,
    parameter int NUM_INPUTS = 16,
    parameter int RES_DEPTH  = 4,
    parameter int SUM_W      = DATAWIDTH + $clog2(NUM_INPUTS - 1) + 2,
    parameter int CNT_W      = $clog2(NUM_INPUTS + 1)
) (
    input logic                clk,
    input logic                rst,
    adder_tree_feeder_if.slave bus
);
    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int OCC_W = $clog2(RES_DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_INPUTS - 1);
    localparam logic [OCC_W:0]   DEPTH_LIM = (OCC_W + 1)'(RES_DEPTH);

    typedef enum logic {FILL, ISSUE} state_t;

    state_t                               state;
    state_t                               state_next;
    logic [NUM_INPUTS-1:0][DATAWIDTH-1:0] lane_buf;
    logic [CNT_W-1:0]                     idx;
    logic                                 accept;
    logic                                 issue;
    logic                                 credit;
    logic                                 sum_ok;
    logic                                 pop;

    logic                                 t_valid_q;
    logic [NUM_INPUTS-1:0][DATAWIDTH-1:0] t_data_q;
    logic                                 err_q;

    logic [OCC_W-1:0]                     outstanding;
    logic [OCC_W-1:0]                     res_occ;
    logic [CNT_W-1:0]                     tag_mem [RES_DEPTH];
    logic [PTR_W-1:0]                     tag_wr;
    logic [PTR_W-1:0]                     tag_rd;
    logic [CNT_W+SUM_W-1:0]               res_mem [RES_DEPTH];
    logic [PTR_W-1:0]                     res_wr;
    logic [PTR_W-1:0]                     res_rd;

    // A vector may only enter the tree if its result is sure to find a FIFO slot,
    // because the tree has no way to stall.
    assign credit = ({1'b0, outstanding} + {1'b0, res_occ}) < DEPTH_LIM;
    assign sum_ok = bus.t_sum_valid && (outstanding != '0);
    assign pop    = (res_occ != '0) && bus.m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        bus.s_ready = 1'b0;
        accept      = 1'b0;
        issue       = 1'b0;
        case (state)
            FILL: begin
                bus.s_ready = !rst;
                accept      = bus.s_valid && !rst;
                if (accept && ((idx == LAST_IDX) || bus.s_last)) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (credit) begin
                    issue      = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Clearing the buffer on issue is what keeps unused lanes of short packets zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_buf  <= '0;
            idx       <= '0;
            t_valid_q <= 1'b0;
            t_data_q  <= '0;
        end else begin
            t_valid_q <= issue;
            if (issue) begin
                t_data_q <= lane_buf;
                lane_buf <= '0;
                idx      <= '0;
            end else if (accept) begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (idx == CNT_W'(i)) begin
                        lane_buf[i] <= bus.s_data;
                    end
                end
                idx <= idx + CNT_W'(1);
            end
        end
    end

    // At issue time idx already equals the number of words written, i.e. the tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wr      <= '0;
            tag_rd      <= '0;
            res_wr      <= '0;
            res_rd      <= '0;
            outstanding <= '0;
            res_occ     <= '0;
            err_q       <= 1'b0;
        end else begin
            if (issue) begin
                tag_mem[tag_wr] <= idx;
                tag_wr          <= tag_wr + PTR_W'(1);
            end
            if (sum_ok) begin
                res_mem[res_wr] <= {tag_mem[tag_rd], bus.t_sum};
                res_wr          <= res_wr + PTR_W'(1);
                tag_rd          <= tag_rd + PTR_W'(1);
            end
            if (pop) begin
                res_rd <= res_rd + PTR_W'(1);
            end
            outstanding <= outstanding + OCC_W'(issue) - OCC_W'(sum_ok);
            res_occ     <= res_occ + OCC_W'(sum_ok) - OCC_W'(pop);
            if (bus.t_sum_valid && (outstanding == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.t_valid                = t_valid_q;
    assign bus.t_data                 = t_data_q;
    assign bus.m_valid                = (res_occ != '0);
    assign {bus.m_count, bus.m_sum}   = res_mem[res_rd];
    assign bus.err_unexpected         = err_q;
endmodule

// File: tb/tb_adder_tree_feeder.sv
// Self-checking bench for adder_tree_feeder: a behavioural tree model answers each
// vector after a fixed latency, and scoreboards check issued lanes and returned results.
module tb_adder_tree_feeder;
    localparam int DW  = 8;
    localparam int NI  = 16;
    localparam int RD  = 4;
    localparam int SW  = DW + $clog2(NI - 1) + 2;
    localparam int CW  = $clog2(NI + 1);
    localparam int LAT = 3;

    typedef logic [NI-1:0][DW-1:0] lanes_t;
    typedef struct packed {
        logic [SW-1:0] sum;
        logic [CW-1:0] cnt;
    } res_t;

    logic clk = 1'b0;
    logic rst;

    adder_tree_feeder_if #(.DATAWIDTH(DW), .NUM_INPUTS(NI)) bus ();

    adder_tree_feeder #(
        .DATAWIDTH (DW),
        .NUM_INPUTS(NI),
        .RES_DEPTH (RD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int        tests = 0;
    int        fails = 0;
    int        cyc = 0;
    int        pulse_cnt = 0;
    int        res_cnt = 0;
    int        last_pulse_cyc = 0;
    int        accept_cyc = 0;
    int        inject_cnt = 0;
    logic [SW-1:0] inject_val = '0;
    bit        rand_ready = 1'b0;
    bit        m_ready_dir = 1'b1;
    lanes_t    lane_q[$];
    res_t      res_q[$];
    logic [DW-1:0] pkt_words [NI];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: timed out waiting, got none expected event", name);
    endtask

    // Adder tree stand-in: sums all lanes of a vector and returns it LAT cycles later.
    initial begin
        bit            pipe_v [LAT];
        logic [SW-1:0] pipe_s [LAT];
        int            seen;
        int            s;
        seen = 0;
        for (int i = 0; i < LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_s[i] = '0;
        end
        bus.t_sum_valid = 1'b0;
        bus.t_sum       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < LAT; i++) pipe_v[i] = 1'b0;
                bus.t_sum_valid = 1'b0;
                bus.t_sum       = '0;
                seen            = inject_cnt;
            end else begin
                if (inject_cnt != seen) begin
                    bus.t_sum_valid = 1'b1;
                    bus.t_sum       = inject_val;
                    seen            = inject_cnt;
                end else begin
                    bus.t_sum_valid = pipe_v[LAT-1];
                    bus.t_sum       = pipe_s[LAT-1];
                end
                for (int i = LAT - 1; i > 0; i--) begin
                    pipe_v[i] = pipe_v[i-1];
                    pipe_s[i] = pipe_s[i-1];
                end
                s = 0;
                for (int i = 0; i < NI; i++) s += int'(bus.t_data[i]);
                pipe_v[0] = bus.t_valid;
                pipe_s[0] = SW'(s);
            end
        end
    end

    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : m_ready_dir;
        end
    end

    // Monitors: every issued vector and every consumed result is matched against the queues.
    initial begin
        lanes_t exp_lanes;
        res_t   exp_res;
        forever begin
            @(negedge clk);
            if (!rst && bus.t_valid) begin
                pulse_cnt++;
                last_pulse_cyc = cyc;
                if (lane_q.size() == 0) begin
                    check_output("t_valid_unexpected", 128'(1), 128'(0));
                end else begin
                    exp_lanes = lane_q.pop_front();
                    check_output("t_data", 128'(bus.t_data), 128'(exp_lanes));
                end
            end
            if (!rst && bus.m_valid && bus.m_ready) begin
                res_cnt++;
                if (res_q.size() == 0) begin
                    check_output("m_valid_unexpected", 128'(1), 128'(0));
                end else begin
                    exp_res = res_q.pop_front();
                    check_output("m_sum", 128'(bus.m_sum), 128'(exp_res.sum));
                    check_output("m_count", 128'(bus.m_count), 128'(exp_res.cnt));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!bus.s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) report_timeout("s_ready");
        accept_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    // Sends pkt_words[0..len-1]; the expected vector is the words zero-padded, the
    // expected result is their plain sum together with len.
    task automatic apply_stimulus(input int len, input bit close, input bit record);
        lanes_t lanes = '0;
        int     sum = 0;
        for (int i = 0; i < len; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = pkt_words[i];
            bus.s_last  = close && (i == len - 1);
            wait_accept();
            lanes[i] = pkt_words[i];
            sum     += int'(pkt_words[i]);
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        if (record) begin
            lane_q.push_back(lanes);
            res_q.push_back('{sum: SW'(sum), cnt: CW'(len)});
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((res_q.size() != 0 || lane_q.size() != 0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (res_q.size() != 0 || lane_q.size() != 0) report_timeout("drain");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int rbase;
        int len;
        int n;
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_s_ready", 128'(bus.s_ready), 128'(0));
        check_output("reset_t_valid", 128'(bus.t_valid), 128'(0));
        check_output("reset_t_data", 128'(bus.t_data), 128'(0));
        check_output("reset_m_valid", 128'(bus.m_valid), 128'(0));
        check_output("reset_err", 128'(bus.err_unexpected), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        base = pulse_cnt;
        for (int i = 0; i < NI; i++) pkt_words[i] = DW'(i + 1);
        apply_stimulus(16, 1'b1, 1'b1);
        wait_idle();
        check_int("full_pulses", pulse_cnt - base, 1);
        check_int("issue_latency", last_pulse_cyc - accept_cyc, 2);

        pkt_words[0] = 8'd5;
        pkt_words[1] = 8'd6;
        pkt_words[2] = 8'd7;
        apply_stimulus(3, 1'b1, 1'b1);
        wait_idle();

        rand_ready = 1'b1;
        repeat (20) begin
            len = $urandom_range(1, NI);
            for (int i = 0; i < len; i++) pkt_words[i] = DW'($urandom_range(0, 255));
            apply_stimulus(len, (len < NI) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1);
        end
        rand_ready  = 1'b0;
        m_ready_dir = 1'b1;
        wait_idle();

        m_ready_dir = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        base  = pulse_cnt;
        rbase = res_cnt;
        for (int i = 0; i < NI; i++) pkt_words[i] = 8'd1;
        repeat (5) apply_stimulus(16, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_int("bp_pulses_held", pulse_cnt - base, 4);
        check_output("bp_s_ready", 128'(bus.s_ready), 128'(0));
        check_output("bp_m_valid", 128'(bus.m_valid), 128'(1));
        check_int("bp_results_held", res_cnt - rbase, 0);
        @(posedge clk);
        #1;
        m_ready_dir = 1'b1;
        wait_idle();
        check_int("bp_pulses_final", pulse_cnt - base, 5);
        check_int("bp_results_final", res_cnt - rbase, 5);

        // Result push lands on the same edge as the first pop of a loaded FIFO.
        m_ready_dir = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rbase = res_cnt;
        for (int k = 0; k < 3; k++) begin
            pkt_words[0] = DW'(10 + k);
            apply_stimulus(1, 1'b1, 1'b1);
        end
        repeat (10) @(posedge clk);
        #1;
        pkt_words[0] = 8'd20;
        apply_stimulus(1, 1'b1, 1'b1);
        n = 0;
        @(negedge clk);
        while (!bus.t_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.t_valid) report_timeout("sim_issue");
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        m_ready_dir = 1'b1;
        @(posedge clk);
        #1;
        wait_idle();
        check_int("sim_results", res_cnt - rbase, 4);

        inject_val = SW'(9);
        inject_cnt++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("unexp_err", 128'(bus.err_unexpected), 128'(1));
        check_output("unexp_m_valid", 128'(bus.m_valid), 128'(0));
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_output("unexp_err_sticky", 128'(bus.err_unexpected), 128'(1));
        check_output("unexp_m_valid_late", 128'(bus.m_valid), 128'(0));
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) pkt_words[i] = DW'(30 + i);
        apply_stimulus(7, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("midfill_err_cleared", 128'(bus.err_unexpected), 128'(0));
        check_output("midfill_m_valid", 128'(bus.m_valid), 128'(0));
        check_output("midfill_s_ready", 128'(bus.s_ready), 128'(1));
        @(posedge clk);
        #1;
        pkt_words[0] = 8'd2;
        pkt_words[1] = 8'd3;
        apply_stimulus(2, 1'b1, 1'b1);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
